// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states,
// mode encodings, default word geometry and the digit-counter width helper.
package serial_addsub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   localparam int DEF_DIGIT_W = 1;
   localparam int DEF_WORD_W  = 8;

   // Width of a counter indexing n digits (n >= 2, so never below one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT_W-bit ripple adder with carry-in; also exposes the carry
// into the MSB so the parent can derive signed overflow.
module serial_addsub_digit_adder #(
   parameter int W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         msb_cin
);

   logic [W:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < W; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout    = carry[W];
   assign msb_cin = carry[W-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with start/last word framing, LSD first.
// Optional signed-overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int DIGIT_W = DEF_DIGIT_W,
   parameter int WORD_W  = DEF_WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sub,
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   output logic [DIGIT_W-1:0] s,
   output logic               s_valid,
   output logic               s_last,
   output logic               busy,
   output logic               carry_out,
   output logic               ovf
);

   localparam int               N        = WORD_W / DIGIT_W;
   localparam int               CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               mode_r, c_reg;
   logic               accept, take, last_digit, mode_eff, c_in;
   logic [DIGIT_W-1:0] y_eff, sum;
   logic               c_next, msb_cin;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      take       = 1'b0;
      last_digit = 1'b0;
      mode_eff   = mode_r;
      c_in       = c_reg;
      case (state)
         IDLE: begin
            if (start) begin
               // Digit 0 uses the live sub as both mode and carry-in.
               accept    = 1'b1;
               take      = 1'b1;
               mode_eff  = sub;
               c_in      = sub;
               cnt_nxt   = CNT_W'(1);
               state_nxt = RUN;
            end
         end
         RUN: begin
            take    = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
               last_digit = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      y_eff = (mode_eff == MODE_SUB) ? ~y : y;
   end

   serial_addsub_digit_adder #(.W(DIGIT_W)) u_adder (
      .a       (x),
      .b       (y_eff),
      .cin     (c_in),
      .sum     (sum),
      .cout    (c_next),
      .msb_cin (msb_cin)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         mode_r    <= MODE_ADD;
         c_reg     <= 1'b0;
         s         <= '0;
         s_valid   <= 1'b0;
         s_last    <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         s_valid <= take;
         s_last  <= last_digit;
         if (accept)     mode_r    <= sub;
         if (take) begin
            s     <= sum;
            c_reg <= c_next;
         end
         if (last_digit) carry_out <= c_next;
      end
   end

   assign busy = (state == RUN);

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             ovf_r <= 1'b0;
      else if (last_digit) ovf_r <= msb_cin ^ c_next;
   end

   assign ovf = ovf_r;
`else
   logic unused_msb_cin;

   assign unused_msb_cin = msb_cin;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: an 8-bit bit-serial instance and a
// 16-bit nibble-serial instance, checked against a plain-arithmetic word model.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, sub_a, s_valid_a, s_last_a, busy_a, carry_out_a, ovf_a;
   logic [0:0] x_a, y_a, s_a;
   logic       start_b, sub_b, s_valid_b, s_last_b, busy_b, carry_out_b, ovf_b;
   logic [3:0] x_b, y_b, s_b;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] wx[8], wy[8], got_r[8];
   bit          wsub[8], got_co[8], got_ov[8];
   int          frame_err[8];
   int          inject_t = -1;

   always #5 clk = ~clk;

   serial_addsub #(.DIGIT_W(1), .WORD_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .sub(sub_a), .x(x_a), .y(y_a),
      .s(s_a), .s_valid(s_valid_a), .s_last(s_last_a), .busy(busy_a),
      .carry_out(carry_out_a), .ovf(ovf_a)
   );

   serial_addsub #(.DIGIT_W(4), .WORD_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .sub(sub_b), .x(x_b), .y(y_b),
      .s(s_b), .s_valid(s_valid_b), .s_last(s_last_b), .busy(busy_b),
      .carry_out(carry_out_b), .ovf(ovf_b)
   );

   // Word-level reference: modular result, unsigned carry/no-borrow, signed range overflow.
   function automatic void model(input int wb, input logic [15:0] xv, input logic [15:0] yv,
                                 input bit sb, output logic [15:0] r, output bit co, output bit ov);
      longint m, half, xa, ya, full, xs, ys, fs;
      m    = longint'(1) << wb;
      half = m / 2;
      xa   = longint'(xv) % m;
      ya   = longint'(yv) % m;
      full = sb ? xa - ya : xa + ya;
      r    = 16'(((full % m) + m) % m);
      co   = sb ? (xa >= ya) : (full >= m);
      xs   = (xa >= half) ? xa - m : xa;
      ys   = (ya >= half) ? ya - m : ya;
      fs   = sb ? xs - ys : xs + ys;
      ov   = OVF_ON && ((fs < -half) || (fs >= half));
   endfunction

   // Streams nw words back-to-back into one instance, collecting each result
   // word and counting framing deviations (s_valid, s_last, busy) per word.
   task automatic run_words(input bit inst, input int nw);
      int n, d, w, k;
      logic v, l, b, co, ov;
      logic [3:0] sv;
      logic [15:0] tmp;
      n = inst ? 4 : 8;
      d = inst ? 4 : 1;
      for (int i = 0; i < nw; i++) begin
         got_r[i] = '0; frame_err[i] = 0; got_co[i] = 1'b0; got_ov[i] = 1'b0;
      end
      for (int t = 0; t <= nw * n; t++) begin
         @(negedge clk);
         if (t > 0) begin
            w  = (t - 1) / n;
            k  = (t - 1) % n;
            v  = inst ? s_valid_b : s_valid_a;
            l  = inst ? s_last_b : s_last_a;
            b  = inst ? busy_b : busy_a;
            co = inst ? carry_out_b : carry_out_a;
            ov = inst ? ovf_b : ovf_a;
            sv = inst ? s_b : {3'b000, s_a};
            if (v !== 1'b1) frame_err[w]++;
            if (l !== (k == n - 1)) frame_err[w]++;
            if (b !== (k != n - 1)) frame_err[w]++;
            got_r[w] = got_r[w] | (16'(sv) << (k * d));
            if (k == n - 1) begin
               got_co[w] = co;
               got_ov[w] = ov;
            end
         end
         if (t < nw * n) begin
            w   = t / n;
            k   = t % n;
            tmp = wx[w] >> (k * d);
            if (inst) x_b = tmp[3:0]; else x_a = tmp[0];
            tmp = wy[w] >> (k * d);
            if (inst) y_b = tmp[3:0]; else y_a = tmp[0];
            if (inst) begin
               start_b = (k == 0) || (t == inject_t);
               sub_b   = (k == 0) ? wsub[w] : ~wsub[w];
            end else begin
               start_a = (k == 0) || (t == inject_t);
               sub_a   = (k == 0) ? wsub[w] : ~wsub[w];
            end
         end else begin
            start_a = 1'b0; start_b = 1'b0;
            x_a = 1'($urandom); y_a = 1'($urandom);
            x_b = 4'($urandom); y_b = 4'($urandom);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start_a = 1'b1; sub_a = 1'b1; x_a = 1'b1; y_a = 1'b0;
      start_b = 1'b1; sub_b = 1'b0; x_b = 4'hF; y_b = 4'h1;
      #3;
      n_checks++;
      if ({s_a, s_valid_a, s_last_a, busy_a, carry_out_a, ovf_a} !== 6'b0)
         $display("FAIL reset_a_async: got %b expected 000000",
                  {s_a, s_valid_a, s_last_a, busy_a, carry_out_a, ovf_a});
      else n_pass++;
      n_checks++;
      if ({s_b, s_valid_b, s_last_b, busy_b, carry_out_b, ovf_b} !== 9'b0)
         $display("FAIL reset_b_async: got %b expected 000000000",
                  {s_b, s_valid_b, s_last_b, busy_b, carry_out_b, ovf_b});
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({s_valid_a, busy_a, s_valid_b, busy_b} !== 4'b0)
         $display("FAIL reset_held_start: got %b expected 0000",
                  {s_valid_a, busy_a, s_valid_b, busy_b});
      else n_pass++;
      start_a = 1'b0; start_b = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({s_valid_a, s_valid_b} !== 2'b0)
         $display("FAIL idle_no_start: got %b expected 00", {s_valid_a, s_valid_b});
      else n_pass++;
   endtask

   task automatic test_directed_a;
      logic [15:0] tx[7]  = '{16'h5A, 16'hFF, 16'h10, 16'h01, 16'h7F, 16'h80, 16'h10};
      logic [15:0] ty[7]  = '{16'h3C, 16'h01, 16'h01, 16'h02, 16'h01, 16'h01, 16'h20};
      bit          ts[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] tr[7]  = '{16'h96, 16'h00, 16'h0F, 16'hFF, 16'h80, 16'h7F, 16'h30};
      bit          tco[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      bit          tov[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         wx[0] = tx[i]; wy[0] = ty[i]; wsub[0] = ts[i];
         run_words(1'b0, 1);
         n_checks++;
         if (got_r[0] !== tr[i])
            $display("FAIL directed_a[%0d] result: got %h expected %h", i, got_r[0], tr[i]);
         else n_pass++;
         n_checks++;
         if (got_co[0] !== tco[i])
            $display("FAIL directed_a[%0d] carry_out: got %b expected %b", i, got_co[0], tco[i]);
         else n_pass++;
         n_checks++;
         if (got_ov[0] !== (OVF_ON & tov[i]))
            $display("FAIL directed_a[%0d] ovf: got %b expected %b", i, got_ov[0], OVF_ON & tov[i]);
         else n_pass++;
         n_checks++;
         if (frame_err[0] !== 0)
            $display("FAIL directed_a[%0d] framing: got %0d deviations expected 0", i, frame_err[0]);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if ({s_valid_a, s_last_a, busy_a} !== 3'b000)
            $display("FAIL directed_a[%0d] trailing_idle: got %b expected 000",
                     i, {s_valid_a, s_last_a, busy_a});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] tr[4]  = '{16'h2201, 16'h0002, 16'h0000, 16'h0002};
      bit          tco[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      wx[0] = 16'h1234; wy[0] = 16'h0FCD; wsub[0] = 1'b0;
      wx[1] = 16'h0005; wy[1] = 16'h0003; wsub[1] = 1'b1;
      wx[2] = 16'hFFFF; wy[2] = 16'h0001; wsub[2] = 1'b0;
      wx[3] = 16'h0001; wy[3] = 16'h0001; wsub[3] = 1'b0;
      run_words(1'b1, 4);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_r[i] !== tr[i])
            $display("FAIL b2b[%0d] result: got %h expected %h", i, got_r[i], tr[i]);
         else n_pass++;
         n_checks++;
         if (got_co[i] !== tco[i])
            $display("FAIL b2b[%0d] carry_out: got %b expected %b", i, got_co[i], tco[i]);
         else n_pass++;
         n_checks++;
         if (got_ov[i] !== 1'b0)
            $display("FAIL b2b[%0d] ovf: got %b expected 0", i, got_ov[i]);
         else n_pass++;
         n_checks++;
         if (frame_err[i] !== 0)
            $display("FAIL b2b[%0d] framing: got %0d deviations expected 0", i, frame_err[i]);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored;
      wx[0] = 16'h33; wy[0] = 16'h44; wsub[0] = 1'b0;
      inject_t = 3;
      run_words(1'b0, 1);
      inject_t = -1;
      n_checks++;
      if (got_r[0] !== 16'h77)
         $display("FAIL start_ignored result: got %h expected 77", got_r[0]);
      else n_pass++;
      n_checks++;
      if (got_co[0] !== 1'b0)
         $display("FAIL start_ignored carry_out: got %b expected 0", got_co[0]);
      else n_pass++;
      n_checks++;
      if (frame_err[0] !== 0)
         $display("FAIL start_ignored framing: got %0d deviations expected 0", frame_err[0]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({s_valid_a, busy_a} !== 2'b00)
         $display("FAIL start_ignored no_extra_word: got %b expected 00", {s_valid_a, busy_a});
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      wx[0] = 16'hFF; wy[0] = 16'h01; wsub[0] = 1'b0;
      run_words(1'b0, 1);
      @(negedge clk);
      start_a = 1'b1; sub_a = 1'b0; x_a = 1'b1; y_a = 1'b1;
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         start_a = 1'b0; sub_a = 1'b1; x_a = 1'b1; y_a = 1'b1;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({s_a, s_valid_a, s_last_a, busy_a, carry_out_a, ovf_a} !== 6'b0)
         $display("FAIL reset_mid outputs: got %b expected 000000",
                  {s_a, s_valid_a, s_last_a, busy_a, carry_out_a, ovf_a});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      wx[0] = 16'h01; wy[0] = 16'h01; wsub[0] = 1'b0;
      run_words(1'b0, 1);
      n_checks++;
      if (got_r[0] !== 16'h02)
         $display("FAIL reset_mid next result: got %h expected 02", got_r[0]);
      else n_pass++;
      n_checks++;
      if (got_co[0] !== 1'b0)
         $display("FAIL reset_mid next carry_out: got %b expected 0", got_co[0]);
      else n_pass++;
      n_checks++;
      if (frame_err[0] !== 0)
         $display("FAIL reset_mid next framing: got %0d deviations expected 0", frame_err[0]);
      else n_pass++;
   endtask

   task automatic test_random;
      int nw, wb;
      logic [15:0] er;
      bit eco, eov;
      for (int inst = 0; inst < 2; inst++) begin
         wb = (inst == 1) ? 16 : 8;
         for (int g = 0; g < 8; g++) begin
            nw = int'($urandom_range(1, 3));
            for (int i = 0; i < nw; i++) begin
               wx[i]   = (inst == 1) ? 16'($urandom) : 16'($urandom & 32'hFF);
               wy[i]   = (inst == 1) ? 16'($urandom) : 16'($urandom & 32'hFF);
               wsub[i] = 1'($urandom);
            end
            run_words(inst[0], nw);
            for (int i = 0; i < nw; i++) begin
               model(wb, wx[i], wy[i], wsub[i], er, eco, eov);
               n_checks++;
               if (got_r[i] !== er || got_co[i] !== eco || got_ov[i] !== eov || frame_err[i] !== 0)
                  $display("FAIL random inst%0d %h%s%h: got r=%h c=%b v=%b frame=%0d expected r=%h c=%b v=%b frame=0",
                           inst, wx[i], wsub[i] ? "-" : "+", wy[i], got_r[i], got_co[i],
                           got_ov[i], frame_err[i], er, eco, eov);
               else n_pass++;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed_a();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
